// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID inputs, hazard context and the
// registered operands/controls driven toward EX.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          hold;
    logic          flush;
    logic [DW-1:0] id_A;
    logic [DW-1:0] id_B;
    logic [DW-1:0] id_snex;
    logic [DW-1:0] id_ex;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic          id_uses_rt;
    logic [1:0]    id_ALU_SrcB_ctrl;
    logic [1:0]    id_ALUOp;
    logic          id_RegWrite;
    logic          id_MemRead;
    logic          id_MemWrite;
    logic          id_MemtoReg;
    logic          mem_RegWrite;
    logic [RW-1:0] mem_dest;
    logic          wb_RegWrite;
    logic [RW-1:0] wb_dest;

    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [DW-1:0] snex;
    logic [DW-1:0] ex;
    logic [1:0]    ALU_SrcB_ctrl;
    logic [1:0]    ALUOp;
    logic [1:0]    ALU_SrcA_fwd;
    logic [1:0]    ALU_SrcB_fwd;
    logic [1:0]    ex_rt_fwd;
    logic [RW-1:0] ex_dest;
    logic          ex_RegWrite;
    logic          ex_MemRead;
    logic          ex_MemWrite;
    logic          ex_MemtoReg;
    logic          load_use_stall;

    modport master (
        output hold, flush,
        output id_A, id_B, id_snex, id_ex,
        output id_rs, id_rt, id_rd, id_uses_rt,
        output id_ALU_SrcB_ctrl, id_ALUOp,
        output id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
        output mem_RegWrite, mem_dest, wb_RegWrite, wb_dest,
        input  A, B, snex, ex, ALU_SrcB_ctrl, ALUOp,
        input  ALU_SrcA_fwd, ALU_SrcB_fwd, ex_rt_fwd, ex_dest,
        input  ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
        input  load_use_stall
    );

    modport slave (
        input  hold, flush,
        input  id_A, id_B, id_snex, id_ex,
        input  id_rs, id_rt, id_rd, id_uses_rt,
        input  id_ALU_SrcB_ctrl, id_ALUOp,
        input  id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
        input  mem_RegWrite, mem_dest, wb_RegWrite, wb_dest,
        output A, B, snex, ex, ALU_SrcB_ctrl, ALUOp,
        output ALU_SrcA_fwd, ALU_SrcB_fwd, ex_rt_fwd, ex_dest,
        output ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
        output load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding selects and
// load-use hazard detection (one bubble per load-use pair).
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] snex;
        logic [DW-1:0] ex;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [1:0]    srcb_ctrl;
        logic [1:0]    alu_op;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d;
    logic   stall;
    logic   rs_hit;
    logic   rt_hit;
    logic [1:0] a_fwd;
    logic [1:0] rt_fwd;

    always_comb begin
        d = '{
            a:          bus.id_A,
            b:          bus.id_B,
            snex:       bus.id_snex,
            ex:         bus.id_ex,
            rs:         bus.id_rs,
            rt:         bus.id_rt,
            rd:         bus.id_rd,
            srcb_ctrl:  bus.id_ALU_SrcB_ctrl,
            alu_op:     bus.id_ALUOp,
            reg_write:  bus.id_RegWrite,
            mem_read:   bus.id_MemRead,
            mem_write:  bus.id_MemWrite,
            mem_to_reg: bus.id_MemtoReg
        };
    end

    // Load in EX whose result is needed by the instruction in ID.
    always_comb begin
        rs_hit = (q.rd == bus.id_rs);
        rt_hit = bus.id_uses_rt && (q.rd == bus.id_rt);
        stall  = !bus.flush && q.mem_read && (q.rd != '0)
                 && (rs_hit || rt_hit);
    end

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (bus.flush)
            q <= '0;
        else if (bus.hold)
            q <= q;
        else if (stall)
            q <= '0;
        else
            q <= d;
    end

    // MEM result is newer than WB, so it wins when both match.
    always_comb begin
        a_fwd = 2'd0;
        if (bus.mem_RegWrite && bus.mem_dest != '0
            && bus.mem_dest == q.rs)
            a_fwd = 2'd2;
        else if (bus.wb_RegWrite && bus.wb_dest != '0
                 && bus.wb_dest == q.rs)
            a_fwd = 2'd1;
    end

    always_comb begin
        rt_fwd = 2'd0;
        if (bus.mem_RegWrite && bus.mem_dest != '0
            && bus.mem_dest == q.rt)
            rt_fwd = 2'd2;
        else if (bus.wb_RegWrite && bus.wb_dest != '0
                 && bus.wb_dest == q.rt)
            rt_fwd = 2'd1;
    end

    assign bus.A              = q.a;
    assign bus.B              = q.b;
    assign bus.snex           = q.snex;
    assign bus.ex             = q.ex;
    assign bus.ALU_SrcB_ctrl  = q.srcb_ctrl;
    assign bus.ALUOp          = q.alu_op;
    assign bus.ex_dest        = q.rd;
    assign bus.ex_RegWrite    = q.reg_write;
    assign bus.ex_MemRead     = q.mem_read;
    assign bus.ex_MemWrite    = q.mem_write;
    assign bus.ex_MemtoReg    = q.mem_to_reg;
    assign bus.ALU_SrcA_fwd   = a_fwd;
    assign bus.ex_rt_fwd      = rt_fwd;
    assign bus.ALU_SrcB_fwd   = (q.srcb_ctrl == 2'd0) ? rt_fwd : 2'd0;
    assign bus.load_use_stall = stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, capture, forwarding,
// load-use bubble, flush-over-hold and hold freeze.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.hold = 0; bus.flush = 0;
        bus.id_A = 0; bus.id_B = 0; bus.id_snex = 0; bus.id_ex = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_uses_rt = 0; bus.id_ALU_SrcB_ctrl = 0; bus.id_ALUOp = 0;
        bus.id_RegWrite = 0; bus.id_MemRead = 0;
        bus.id_MemWrite = 0; bus.id_MemtoReg = 0;
        bus.mem_RegWrite = 0; bus.mem_dest = 0;
        bus.wb_RegWrite = 0; bus.wb_dest = 0;
    endtask

    function automatic logic [31:0] ctl();
        return {22'd0, bus.ALU_SrcB_ctrl, bus.ALUOp, bus.ex_RegWrite,
                bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg};
    endfunction

    initial begin
        clear_id();
        rst = 1;
        // 1: reset with random ID inputs
        bus.id_A = $urandom; bus.id_B = $urandom;
        bus.id_snex = $urandom; bus.id_ex = $urandom;
        bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
        bus.id_rd = 5'($urandom); bus.id_uses_rt = 1'($urandom);
        bus.id_ALUOp = 2'($urandom); bus.id_ALU_SrcB_ctrl = 2'($urandom);
        bus.id_RegWrite = 1; bus.id_MemRead = 1;
        bus.id_MemWrite = 1; bus.id_MemtoReg = 1;
        bus.mem_RegWrite = 1; bus.wb_RegWrite = 1;
        tick();
        check("rst_A", bus.A, 0);
        check("rst_B", bus.B, 0);
        check("rst_snex", bus.snex, 0);
        check("rst_ex", bus.ex, 0);
        check("rst_dest", 32'(bus.ex_dest), 0);
        check("rst_ctl", ctl(), 0);
        check("rst_afwd", 32'(bus.ALU_SrcA_fwd), 0);
        check("rst_bfwd", 32'(bus.ALU_SrcB_fwd), 0);
        check("rst_rtfwd", 32'(bus.ex_rt_fwd), 0);
        check("rst_stall", 32'(bus.load_use_stall), 0);
        rst = 0;
        clear_id();

        // 2: basic capture
        bus.id_A = 32'h1234; bus.id_ALUOp = 2;
        bus.id_ALU_SrcB_ctrl = 2; bus.id_snex = 32'hFFFF_FFF0;
        tick();
        check("cap_A", bus.A, 32'h1234);
        check("cap_snex", bus.snex, 32'hFFFF_FFF0);
        check("cap_ALUOp", 32'(bus.ALUOp), 2);
        check("cap_ctrl", 32'(bus.ALU_SrcB_ctrl), 2);

        // 3: forwarding
        clear_id();
        bus.id_rs = 3; bus.id_rt = 4;
        tick();
        bus.mem_RegWrite = 1; bus.mem_dest = 3;
        bus.wb_RegWrite = 1; bus.wb_dest = 3;
        #1 check("fwd_a_mem", 32'(bus.ALU_SrcA_fwd), 2);
        bus.mem_dest = 7; bus.wb_dest = 4;
        #1 check("fwd_b_wb", 32'(bus.ALU_SrcB_fwd), 1);
        check("fwd_rt_wb", 32'(bus.ex_rt_fwd), 1);
        check("fwd_a_none", 32'(bus.ALU_SrcA_fwd), 0);
        bus.mem_dest = 4;
        #1 check("fwd_b_mem", 32'(bus.ALU_SrcB_fwd), 2);
        bus.mem_RegWrite = 0;
        #1 check("fwd_b_nowr", 32'(bus.ALU_SrcB_fwd), 1);
        bus.id_ALU_SrcB_ctrl = 1;
        tick();
        bus.mem_dest = 7;
        #1 check("fwd_b_imm", 32'(bus.ALU_SrcB_fwd), 0);
        check("fwd_rt_imm", 32'(bus.ex_rt_fwd), 1);

        // 4: load-use hazard
        clear_id();
        bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 5;
        bus.id_MemRead = 1; bus.id_RegWrite = 1; bus.id_MemtoReg = 1;
        tick();
        clear_id();
        bus.id_rs = 5; bus.id_rd = 6; bus.id_RegWrite = 1;
        #1 check("lu_stall", 32'(bus.load_use_stall), 1);
        tick();
        check("lu_bubble_ctl", ctl(), 0);
        check("lu_bubble_dest", 32'(bus.ex_dest), 0);
        check("lu_unstall", 32'(bus.load_use_stall), 0);
        tick();
        check("lu_reload", 32'(bus.ex_dest), 6);
        check("lu_reload_rw", 32'(bus.ex_RegWrite), 1);
        clear_id();
        bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 5;
        bus.id_MemRead = 1; bus.id_RegWrite = 1;
        tick();
        clear_id();
        bus.id_rs = 1; bus.id_rt = 5; bus.id_uses_rt = 0;
        #1 check("lu_rt_unused", 32'(bus.load_use_stall), 0);
        bus.id_uses_rt = 1;
        #1 check("lu_rt_used", 32'(bus.load_use_stall), 1);

        // 5: flush beats load-use and hold
        bus.flush = 1; bus.hold = 1;
        #1 check("fl_stall", 32'(bus.load_use_stall), 0);
        tick();
        check("fl_ctl", ctl(), 0);
        check("fl_dest", 32'(bus.ex_dest), 0);
        check("fl_A", bus.A, 0);

        // dest 0 load never stalls
        clear_id();
        bus.id_rs = 1; bus.id_rd = 0; bus.id_MemRead = 1;
        tick();
        check("lu_r0_mr", 32'(bus.ex_MemRead), 1);
        clear_id();
        bus.id_rs = 0;
        #1 check("lu_r0", 32'(bus.load_use_stall), 0);

        // 6: hold freeze
        clear_id();
        bus.id_A = 32'hAAAA_0001; bus.id_rd = 9; bus.id_RegWrite = 1;
        bus.id_rs = 2; bus.id_rt = 8;
        tick();
        check("hd_load", bus.A, 32'hAAAA_0001);
        bus.hold = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_A = 32'h5555 + i; bus.id_rd = 10;
            tick();
            check("hd_A", bus.A, 32'hAAAA_0001);
            check("hd_dest", 32'(bus.ex_dest), 9);
        end
        bus.hold = 0; bus.id_A = 32'h5555;
        tick();
        check("hd_rel_A", bus.A, 32'h5555);
        check("hd_rel_dest", 32'(bus.ex_dest), 10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
